// File: rtl/mem_dump_reader_pkg.sv
// Shared types and default sizes for the port-B memory dump reader.
package mem_dump_reader_pkg;

   localparam int DATA_W_DEF = 16;
   localparam int ADDR_W_DEF = 16;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_ISSUE   = 3'd1,
      ST_CAPTURE = 3'd2,
      ST_OUT     = 3'd3,
      ST_DONE    = 3'd4,
      ST_SUM     = 3'd5
   } state_t;

endpackage

// File: rtl/mem_dump_reader.sv
// Port-B read agent for the shared dual-port bram: on start it walks an
// inclusive address range and streams every word out on a valid/ready port.
// Port B is read-only, so we_b and data_b are tied low.
// Optional build macro MEM_DUMP_CHECKSUM_EN appends a modulo-2^DATA_W sum
// of the dumped words as a final word flagged with dout_last.
module mem_dump_reader
   import mem_dump_reader_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int ADDR_W = ADDR_W_DEF
)(
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic              abort,
   input  logic [ADDR_W-1:0] start_addr,
   input  logic [ADDR_W-1:0] end_addr,
   output logic [ADDR_W-1:0] addr_b,
   output logic              we_b,
   output logic [DATA_W-1:0] data_b,
   input  logic [DATA_W-1:0] q_b,
   output logic [DATA_W-1:0] dout,
   output logic              dout_valid,
   input  logic              dout_ready,
   output logic              dout_last,
   output logic              busy,
   output logic              done,
   output logic              err
);

   localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);

   state_t            state_r;
   logic [ADDR_W-1:0] cur_r;
   logic [ADDR_W-1:0] end_r;
   logic              handshake_s;
`ifdef MEM_DUMP_CHECKSUM_EN
   logic [DATA_W-1:0] sum_r;
`endif

   // Port B never writes the bram.
   assign we_b   = 1'b0;
   assign data_b = {DATA_W{1'b0}};

   // The output register is only ever valid in OUT/SUM, so this is the accept.
   assign handshake_s = dout_valid & dout_ready;

   // Dump sequencer: address walk, word capture, output handshake and pulses.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r    <= ST_IDLE;
         cur_r      <= {ADDR_W{1'b0}};
         end_r      <= {ADDR_W{1'b0}};
         addr_b     <= {ADDR_W{1'b0}};
         dout       <= {DATA_W{1'b0}};
         dout_valid <= 1'b0;
         dout_last  <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
         err        <= 1'b0;
`ifdef MEM_DUMP_CHECKSUM_EN
         sum_r      <= {DATA_W{1'b0}};
`endif
      end else begin
         done <= 1'b0;
         err  <= 1'b0;
         if (abort && (state_r != ST_IDLE)) begin
            // Abort beats a same-cycle handshake; progress is dropped silently.
            state_r    <= ST_IDLE;
            dout_valid <= 1'b0;
            dout_last  <= 1'b0;
            busy       <= 1'b0;
         end else begin
            case (state_r)
               ST_IDLE: begin
                  if (start) begin
                     if (start_addr <= end_addr) begin
                        cur_r   <= start_addr;
                        end_r   <= end_addr;
                        addr_b  <= start_addr;
                        busy    <= 1'b1;
                        state_r <= ST_ISSUE;
`ifdef MEM_DUMP_CHECKSUM_EN
                        sum_r   <= {DATA_W{1'b0}};
`endif
                     end else begin
                        // Reversed range: report and finish without any words.
                        err  <= 1'b1;
                        done <= 1'b1;
                     end
                  end else begin
                     state_r <= ST_IDLE;
                  end
               end

               ST_ISSUE: begin
                  // bram samples addr_b at the end of this cycle.
                  state_r <= ST_CAPTURE;
               end

               ST_CAPTURE: begin
                  dout       <= q_b;
                  dout_valid <= 1'b1;
`ifdef MEM_DUMP_CHECKSUM_EN
                  dout_last  <= 1'b0;
                  sum_r      <= sum_r + q_b;
`else
                  dout_last  <= (cur_r == end_r);
`endif
                  state_r    <= ST_OUT;
               end

               ST_OUT: begin
                  if (handshake_s) begin
                     if (cur_r == end_r) begin
                        // Compare before increment, so end = all-ones never wraps.
`ifdef MEM_DUMP_CHECKSUM_EN
                        dout       <= sum_r;
                        dout_valid <= 1'b1;
                        dout_last  <= 1'b1;
                        state_r    <= ST_SUM;
`else
                        dout_valid <= 1'b0;
                        dout_last  <= 1'b0;
                        done       <= 1'b1;
                        state_r    <= ST_DONE;
`endif
                     end else begin
                        cur_r      <= cur_r + ADDR_ONE;
                        addr_b     <= cur_r + ADDR_ONE;
                        dout_valid <= 1'b0;
                        dout_last  <= 1'b0;
                        state_r    <= ST_ISSUE;
                     end
                  end else begin
                     state_r <= ST_OUT;
                  end
               end

               ST_SUM: begin
`ifdef MEM_DUMP_CHECKSUM_EN
                  if (handshake_s) begin
                     dout_valid <= 1'b0;
                     dout_last  <= 1'b0;
                     done       <= 1'b1;
                     state_r    <= ST_DONE;
                  end else begin
                     state_r <= ST_SUM;
                  end
`else
                  // Unreachable without the checksum; recover to IDLE.
                  dout_valid <= 1'b0;
                  dout_last  <= 1'b0;
                  busy       <= 1'b0;
                  state_r    <= ST_IDLE;
`endif
               end

               ST_DONE: begin
                  busy    <= 1'b0;
                  state_r <= ST_IDLE;
               end

               default: begin
                  dout_valid <= 1'b0;
                  dout_last  <= 1'b0;
                  busy       <= 1'b0;
                  state_r    <= ST_IDLE;
               end
            endcase
         end
      end
   end

endmodule
